// File: rtl/fa_resp_checker.sv
// Exhaustive checker for an external full adder: drives all eight {ci,a,b} vectors in order,
// waits SETTLE cycles on each, compares the returned sum/carry and accumulates an error map.
module fa_resp_checker #(
   parameter int SETTLE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dut_s,
   input  logic       dut_co,
   output logic       tv_ci,
   output logic       tv_a,
   output logic       tv_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_cnt,
   output logic [7:0] err_map
);

   typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;

   localparam logic [7:0] SETTLE_C = 8'(SETTLE);

   state_t     state, state_nx;
   logic [2:0] idx;
   logic [7:0] cnt;
   logic       mism;

   // Case inequality so that an undriven or X response is flagged as a mismatch.
   function automatic logic vec_mismatch(input logic [2:0] v, input logic s, input logic co);
      logic exp_s, exp_co;
      exp_s  = v[2] ^ v[1] ^ v[0];
      exp_co = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      return (s !== exp_s) || (co !== exp_co);
   endfunction

   assign mism = vec_mismatch({tv_ci, tv_a, tv_b}, dut_s, dut_co);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = APPLY;
         APPLY:   state_nx = WAIT;
         WAIT:    if (cnt <= 8'd1) state_nx = CHECK;
         CHECK:   state_nx = (idx == 3'd7) ? DONE : APPLY;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= 3'd0;
         cnt     <= 8'd0;
         tv_ci   <= 1'b0;
         tv_a    <= 1'b0;
         tv_b    <= 1'b0;
         pass    <= 1'b0;
         err_cnt <= 4'd0;
         err_map <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx     <= 3'd0;
                  pass    <= 1'b0;
                  err_cnt <= 4'd0;
                  err_map <= 8'h00;
               end
            end
            APPLY: begin
               {tv_ci, tv_a, tv_b} <= idx;
               cnt                 <= SETTLE_C;
            end
            WAIT: cnt <= cnt - 8'd1;
            CHECK: begin
               if (mism) begin
                  err_map[idx] <= 1'b1;
                  err_cnt      <= err_cnt + 4'd1;
               end
               // Verdict is latched on the way into DONE so it is valid while done is high.
               if (idx != 3'd7) idx  <= idx + 3'd1;
               else             pass <= (err_cnt == 4'd0) && !mism;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fa_resp_checker.sv
// Randomized scoreboard bench for fa_resp_checker: a faultable full-adder model answers the
// checker, and a reference model predicts err_map/err_cnt/pass and the done edge.
module tb_fa_resp_checker;

   typedef struct {
      bit       pass;
      int       cnt;
      bit [7:0] map;
      int       edge_n;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start4, start1;
   logic       s4, co4, s1, co1;
   logic       tv_ci4, tv_a4, tv_b4, busy4, done4, pass4;
   logic       tv_ci1, tv_a1, tv_b1, busy1, done1, pass1;
   logic [3:0] err_cnt4, err_cnt1;
   logic [7:0] err_map4, err_map1;

   logic [7:0] s_flip = 8'h00;
   logic [7:0] co_flip = 8'h00;
   logic       co_stuck0 = 1'b0;

   int   cyc = 0;
   int   n_pass = 0;
   int   n_tot = 0;
   exp_t q4[$];
   exp_t q1[$];

   fa_resp_checker #(.SETTLE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .dut_s(s4), .dut_co(co4),
      .tv_ci(tv_ci4), .tv_a(tv_a4), .tv_b(tv_b4), .busy(busy4), .done(done4),
      .pass(pass4), .err_cnt(err_cnt4), .err_map(err_map4)
   );

   fa_resp_checker #(.SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .dut_s(s1), .dut_co(co1),
      .tv_ci(tv_ci1), .tv_a(tv_a1), .tv_b(tv_b1), .busy(busy1), .done(done1),
      .pass(pass1), .err_cnt(err_cnt1), .err_map(err_map1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Full adders under test, with injectable faults.
   always_comb begin
      logic [2:0] v;
      v   = {tv_ci4, tv_a4, tv_b4};
      s4  = (v[0] ^ v[1] ^ v[2]) ^ s_flip[v];
      co4 = co_stuck0 ? 1'b0 : (((v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2])) ^ co_flip[v]);
   end

   always_comb begin
      logic [2:0] v;
      v   = {tv_ci1, tv_a1, tv_b1};
      s1  = (v[0] ^ v[1] ^ v[2]) ^ s_flip[v];
      co1 = co_stuck0 ? 1'b0 : (((v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2])) ^ co_flip[v]);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Arithmetic reference: a vector is bad when the adder's answer differs from a+b+ci.
   function automatic exp_t model(input int acc, input int settle);
      exp_t e;
      e.cnt = 0;
      e.map = 8'h00;
      for (int v = 0; v < 8; v++) begin
         int tot, good_s, good_co, got_s, got_co;
         tot     = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
         good_s  = tot % 2;
         good_co = (tot >= 2) ? 1 : 0;
         got_s   = good_s ^ int'(s_flip[v]);
         got_co  = co_stuck0 ? 0 : (good_co ^ int'(co_flip[v]));
         if (got_s != good_s || got_co != good_co) begin
            e.map[v] = 1'b1;
            e.cnt++;
         end
      end
      e.pass   = (e.cnt == 0);
      e.edge_n = acc + 8 * (settle + 2);
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && done4) begin
         if (q4.size() == 0) chk("unexpected_done4", 1, 0);
         else begin
            exp_t e;
            e = q4.pop_front();
            chk("done_edge4", cyc, e.edge_n);
            chk("pass4", int'(pass4), int'(e.pass));
            chk("err_cnt4", int'(err_cnt4), e.cnt);
            chk("err_map4", int'(err_map4), int'(e.map));
            chk("busy_at_done4", int'(busy4), 1);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done1) begin
         if (q1.size() == 0) chk("unexpected_done1", 1, 0);
         else begin
            exp_t e;
            e = q1.pop_front();
            chk("done_edge1", cyc, e.edge_n);
            chk("pass1", int'(pass1), int'(e.pass));
            chk("err_cnt1", int'(err_cnt1), e.cnt);
            chk("err_map1", int'(err_map1), int'(e.map));
         end
      end
   end

   task automatic launch4(output exp_t e);
      @(negedge clk);
      e = model(cyc + 1, 4);
      q4.push_back(e);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
   endtask

   task automatic launch1(output exp_t e);
      @(negedge clk);
      e = model(cyc + 1, 1);
      q1.push_back(e);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
   endtask

   task automatic wait4(input string name);
      for (int i = 0; i < 300 && q4.size() != 0; i++) @(negedge clk);
      chk(name, q4.size(), 0);
      @(negedge clk);
   endtask

   task automatic wait1(input string name);
      for (int i = 0; i < 300 && q1.size() != 0; i++) @(negedge clk);
      chk(name, q1.size(), 0);
      @(negedge clk);
   endtask

   // After a run: idle, last vector left on the bus, results held.
   task automatic post_check4(input exp_t e);
      chk("busy_after4", int'(busy4), 0);
      repeat (3) @(negedge clk);
      chk("tv_last4", int'({tv_ci4, tv_a4, tv_b4}), 7);
      chk("map_hold4", int'(err_map4), int'(e.map));
      chk("cnt_hold4", int'(err_cnt4), e.cnt);
      chk("pass_hold4", int'(pass4), int'(e.pass));
   endtask

   task automatic zero_check4(input string name);
      chk({name, "_tv"}, int'({tv_ci4, tv_a4, tv_b4}), 0);
      chk({name, "_busy"}, int'(busy4), 0);
      chk({name, "_done"}, int'(done4), 0);
      chk({name, "_pass"}, int'(pass4), 0);
      chk({name, "_cnt"}, int'(err_cnt4), 0);
      chk({name, "_map"}, int'(err_map4), 0);
   endtask

   initial begin
      exp_t e, e2;
      int   acc;
      start4 = 1'b0;
      start1 = 1'b0;
      #2 rst_n = 1'b0;
      #1 zero_check4("rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Correct adder
      launch4(e);
      wait4("timeout_good");
      post_check4(e);

      // Carry stuck at 0
      co_stuck0 = 1'b1;
      launch4(e);
      wait4("timeout_co0");
      chk("co0_map_const", int'(err_map4), 8'hE8);
      chk("co0_cnt_const", int'(err_cnt4), 4);
      post_check4(e);
      co_stuck0 = 1'b0;

      // Inverted sum
      s_flip = 8'hFF;
      launch4(e);
      wait4("timeout_sinv");
      chk("sinv_map_const", int'(err_map4), 8'hFF);
      chk("sinv_cnt_const", int'(err_cnt4), 8);
      post_check4(e);

      // Random fault patterns
      for (int r = 0; r < 6; r++) begin
         s_flip  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         co_flip = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         launch4(e);
         wait4("timeout_rand");
         post_check4(e);
      end

      // Start held high through the whole run and across DONE
      s_flip  = 8'h10;
      co_flip = 8'h00;
      @(negedge clk);
      acc = cyc + 1;
      e = model(acc, 4);
      q4.push_back(e);
      start4 = 1'b1;
      e2 = model(e.edge_n + 2, 4);
      q4.push_back(e2);
      while (cyc < e2.edge_n - 48) @(negedge clk);
      start4 = 1'b0;
      chk("restart_busy", int'(busy4), 1);
      chk("restart_clr_cnt", int'(err_cnt4), 0);
      chk("restart_clr_map", int'(err_map4), 0);
      chk("restart_clr_pass", int'(pass4), 0);
      wait4("timeout_restart");
      post_check4(e2);

      // Reset mid-run at edge 20, then a clean run
      s_flip = 8'hFF;
      @(negedge clk);
      acc = cyc + 1;
      e = model(acc, 4);
      q4.push_back(e);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      while (cyc < acc + 20) @(negedge clk);
      chk("pre_abort_map_nonzero", int'(err_map4 != 8'h00), 1);
      rst_n = 1'b0;
      #1 zero_check4("abort");
      q4.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      s_flip = 8'h00;
      launch4(e);
      wait4("timeout_after_abort");
      post_check4(e);

      // SETTLE=1 instance
      launch1(e);
      wait1("timeout_s1_good");
      chk("s1_busy_after", int'(busy1), 0);
      chk("s1_tv_last", int'({tv_ci1, tv_a1, tv_b1}), 7);
      s_flip  = 8'($urandom);
      co_flip = 8'($urandom);
      launch1(e);
      wait1("timeout_s1_rand");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
